// File: rtl/conv_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_drain
//  Description : Drains the four layer-2 result buffers of the convolution
//                engine after it completes. Each address is read once, the
//                four bytes are captured into a holding register and emitted
//                one by one (channel 0..3) on a valid/ready stream. The final
//                word of a drain (last address, channel 3) carries out_last.
//
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                conv_done         - engine completion level (rising edge
//                                    starts a drain)
//                rd_en, rd_addr    - shared read strobe/address to buffers
//                rd_data0..3       - buffer read data, 1 cycle after rd_en
//                out_data, out_ch,
//                out_valid,
//                out_ready,
//                out_last          - result stream
//                busy              - drain in progress
//                drain_done        - one-cycle pulse at end of a drain
//
//  Options     : `define CONV_DRAIN_RELU_EN to clamp negative (signed) bytes
//                to 8'h00 on capture. Undefined: bytes pass bit-exact.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_result_drain #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data0,
    input  logic [7:0]    rd_data1,
    input  logic [7:0]    rd_data2,
    input  logic [7:0]    rd_data3,
    output logic [7:0]    out_data,
    output logic [1:0]    out_ch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          drain_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_done_q;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_ch;
    logic [7:0]    r_hold [4];

    logic w_start;
    logic w_accept;
    logic w_ch_last;
    logic w_addr_last;

    function automatic logic [7:0] f_relu(input logic [7:0] b);
`ifdef CONV_DRAIN_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    assign w_start     = conv_done && !r_done_q;
    assign w_accept    = (r_state == S_EMIT) && out_ready;
    assign w_ch_last   = (r_ch == 2'd3);
    assign w_addr_last = (r_addr == c_last_addr);

    // done_q resets high so a conv_done already asserted at reset release
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_done_q <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= conv_done;
        end
    end

    // Address/channel counters and holding register. The address only moves
    // on the edge that enters FETCH, so rd_addr is stable whenever rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_ch   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_ch      <= 2'd0;
                    r_hold[0] <= f_relu(rd_data0);
                    r_hold[1] <= f_relu(rd_data1);
                    r_hold[2] <= f_relu(rd_data2);
                    r_hold[3] <= f_relu(rd_data3);
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (!w_ch_last) begin
                            r_ch <= r_ch + 2'd1;
                        end else if (!w_addr_last) begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        rd_addr     = r_addr;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_ch      = 2'd0;
        out_last    = 1'b0;
        busy        = 1'b1;
        drain_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en       = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = r_hold[r_ch];
                out_ch    = r_ch;
                out_last  = w_addr_last && w_ch_last;
                if (w_accept && w_ch_last) begin
                    w_state_nxt = w_addr_last ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                drain_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_result_drain
//  Description : Directed self-checking bench for conv_result_drain
//                (DEPTH=4). A buffer model answers reads one cycle after
//                rd_en; expected words are queued when a drain is started
//                and compared as the stream hands them over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_drain;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          conv_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data0, rd_data1, rd_data2, rd_data3;
    logic [7:0]    out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          drain_done;

    conv_result_drain #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .conv_done(conv_done),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_data2(rd_data2), .rd_data3(rd_data3),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    // Buffer model: registered read, data valid the cycle after rd_en.
    logic [7:0] mem [4][DEPTH];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem[0][rd_addr];
            rd_data1 <= mem[1][rd_addr];
            rd_data2 <= mem[2][rd_addr];
            rd_data3 <= mem[3][rd_addr];
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Ready driver: constant 1, or the repeating pattern 1,0,0,1.
    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    int         bp_idx  = 0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    logic [10:0] sb_q [$];   // {ch, last, data}
    int first_rd, first_val, last_hs, done_cyc;
    int rd_cnt, hs_cnt, last_cnt, stalls, drains;
    logic       prev_stall = 1'b0;
    logic [10:0] prev_word;

    function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef CONV_DRAIN_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    // Monitor: sample mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        logic [10:0] obs, exp_w;
        obs = {out_ch, out_last, out_data};
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && first_val < 0) first_val = cyc;
        if (prev_stall && !rst) begin
            tests++;
            assert (out_valid === 1'b1 && obs === prev_word) else begin
                fails++;
                $error("FAIL stall_hold observed=%h expected=%h", obs, prev_word);
            end
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            last_hs = cyc;
            if (out_last) last_cnt++;
            exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 11'h7ff;
            tests++;
            assert (obs === exp_w) else begin
                fails++;
                $error("FAIL word observed=%h expected=%h", obs, exp_w);
            end
        end
        if (out_valid && !out_ready) stalls++;
        prev_stall = out_valid && !out_ready;
        prev_word  = obs;
        if (drain_done) begin
            drains++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stats();
        first_rd = -1; first_val = -1; last_hs = -1; done_cyc = -1;
        rd_cnt = 0; hs_cnt = 0; last_cnt = 0; stalls = 0; drains = 0;
    endtask

    task automatic load_base();
        for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < 4; c++)
                mem[c][a] = 8'(8'h10 * (c + 1) + a);
    endtask

    task automatic push_expected();
        for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < 4; c++)
                sb_q.push_back({2'(c), (a == DEPTH - 1 && c == 3), relu(mem[c][a])});
    endtask

    task automatic raise_done(output int start);
        @(posedge clk);
        #1 conv_done = 1'b1;
        start = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (drains == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", drains, 1);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        conv_done = 1'b1;
        clear_stats();
        load_base();
        #3;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);

        // Release reset with conv_done already high: no drain.
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        check("lvl_no_rd_en", rd_cnt, 0);
        check("lvl_busy", busy, 0);

        // Fresh edge: basic drain, conv_done left high throughout.
        #1 conv_done = 1'b0;
        @(posedge clk);
        clear_stats();
        push_expected();
        raise_done(s);
        wait_drain(200);
        check("basic_first_rd", first_rd, s + 1);
        check("basic_first_valid", first_val, s + 3);
        check("basic_words", hs_cnt, 16);
        check("basic_span", last_hs - first_rd + 1, 24);
        check("basic_done_lat", done_cyc, last_hs + 1);
        check("basic_last_cnt", last_cnt, 1);
        check("basic_q_empty", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        check("basic_busy_after", busy, 0);

        // Re-trigger mid-drain is ignored.
        #1 conv_done = 1'b0;
        @(posedge clk);
        clear_stats();
        push_expected();
        raise_done(s);
        repeat (8) @(posedge clk);
        #1 conv_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 conv_done = 1'b1;
        wait_drain(200);
        repeat (10) @(posedge clk);
        check("retrig_words", hs_cnt, 16);
        check("retrig_reads", rd_cnt, DEPTH);
        check("retrig_drains", drains, 1);
        check("retrig_busy", busy, 0);

        // Back-pressure: duration grows by the number of stalled cycles.
        #1 conv_done = 1'b0;
        @(posedge clk);
        clear_stats();
        push_expected();
        bp_mode = 1'b1;
        raise_done(s);
        wait_drain(400);
        check("bp_words", hs_cnt, 16);
        check("bp_span", last_hs - first_rd + 1, 24 + stalls);
        check("bp_done_lat", done_cyc, last_hs + 1);
        check("bp_stalls_seen", (stalls > 0) ? 1 : 0, 1);
        check("bp_last_cnt", last_cnt, 1);
        bp_mode = 1'b0;
        #1 conv_done = 1'b0;
        repeat (2) @(posedge clk);

        // Reset after the 6th accepted word, then a clean restart.
        clear_stats();
        push_expected();
        raise_done(s);
        @(posedge clk);
        #1 conv_done = 1'b0;
        for (int n = 0; n < 200 && hs_cnt < 6; n++) @(negedge clk);
        check("mid_reach6", hs_cnt, 6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", rd_en, 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        check("mid_no_done", drains, 0);
        clear_stats();
        push_expected();
        raise_done(s);
        @(posedge clk);
        #1 conv_done = 1'b0;
        wait_drain(200);
        check("mid_restart_rd", first_rd, s + 1);
        check("mid_restart_words", hs_cnt, 16);

        // Negative bytes on channel 0.
        mem[0][0] = 8'h80; mem[0][1] = 8'hFF; mem[0][2] = 8'h7F; mem[0][3] = 8'h00;
        repeat (2) @(posedge clk);
        clear_stats();
        push_expected();
        raise_done(s);
        @(posedge clk);
        #1 conv_done = 1'b0;
        wait_drain(200);
        check("relu_words", hs_cnt, 16);
        check("relu_q_empty", sb_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
